// File: rtl/serial_sorter_if.sv
// Load/drain handshake bundle for serial_sorter.
// Upstream pushes elements in, downstream pulls sorted elements out.
interface serial_sorter_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/serial_sorter.sv
// Frame sorter: loads N elements, bubble-sorts them on a fixed schedule,
// then streams them out smallest first.
module serial_sorter #(
    parameter int W = 4,
    parameter int N = 5
) (
    input  logic            clk,
    input  logic            rst,
    serial_sorter_if.slave  bus,
    output logic            busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] PEN  = CW'(N - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] k;
    logic [CW-1:0] p;
    logic [CW-1:0] j;
    logic [CW-1:0] jn;
    logic [CW-1:0] r;
    logic [W-1:0]  slot [N];
    logic          in_fire;
    logic          out_fire;
    logic          sort_done;

    assign jn        = j + ONE;
    assign in_fire   = bus.in_valid && (state == LOAD);
    assign out_fire  = bus.out_ready && (state == DRAIN);
    assign sort_done = (j == PEN) && (p == PEN);

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = slot[r];
    assign busy          = (state != LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (in_fire && k == LAST) state_nx = SORT;
            SORT:    if (sort_done) state_nx = DRAIN;
            DRAIN:   if (out_fire && r == LAST) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
            p <= '0;
            j <= '0;
            r <= '0;
            for (int i = 0; i < N; i++) begin
                slot[i] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_fire) begin
                        slot[k] <= bus.in_data;
                        k       <= (k == LAST) ? '0 : k + ONE;
                    end
                end
                SORT: begin
                    // strict compare keeps equal keys in place
                    if (slot[j] > slot[jn]) begin
                        slot[j]  <= slot[jn];
                        slot[jn] <= slot[j];
                    end
                    if (j == PEN) begin
                        j <= '0;
                        p <= (p == PEN) ? '0 : p + ONE;
                    end else begin
                        j <= jn;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        r <= (r == LAST) ? '0 : r + ONE;
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sorter.sv
// Directed bench for serial_sorter at W=4, N=5.
// Each scenario task checks its own expected values inline.
module tb_serial_sorter;
    typedef logic [3:0] frame_t [5];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   vecs = 0;
    int   errs = 0;

    serial_sorter_if #(.W(4)) bus ();

    serial_sorter #(.W(4), .N(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic load_frame(input frame_t f, input bit stray);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            vecs++;
            if (bus.in_ready !== 1'b1) begin
                errs++;
                $display("FAIL load_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = stray;
        bus.in_data  = stray ? 4'd6 : 4'd0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vecs++;
        if (bus.out_valid !== 1'b1) begin
            errs++;
            $display("FAIL wait_valid: timeout got %b want 1", bus.out_valid);
        end
    endtask

    task automatic drain(input frame_t exp, input bit toggle, input string name);
        int       got  = 0;
        int       cyc  = 0;
        bit       hold = 1'b0;
        logic [3:0] held = '0;
        while (got < 5 && cyc < 100) begin
            bus.out_ready = toggle ? ~cyc[0] : 1'b1;
            if (hold) begin
                vecs++;
                if (bus.out_data !== held) begin
                    errs++;
                    $display("FAIL %s_stable: got %0d want %0d", name, bus.out_data, held);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                vecs++;
                if (bus.out_data !== exp[got]) begin
                    errs++;
                    $display("FAIL %s_out[%0d]: got %0d want %0d", name, got, bus.out_data, exp[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        vecs++;
        if (got != 5) begin
            errs++;
            $display("FAIL %s_count: got %0d want 5", name, got);
        end
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL %s_back_to_load: got rdy=%b vld=%b busy=%b want 1 0 0", name, bus.in_ready, bus.out_valid, busy);
        end
        if (!toggle) begin
            vecs++;
            if (cyc != 5) begin
                errs++;
                $display("FAIL %s_consecutive: got %0d cycles want 5", name, cyc);
            end
        end
    endtask

    task automatic check_idle(input string name);
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 4'd0) begin
            errs++;
            $display("FAIL %s: got rdy=%b vld=%b busy=%b data=%0d want 1 0 0 0", name, bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b0;
        #1;
        check_idle(name);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #3;
        check_idle("reset_state");
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("after_release");
    endtask

    task automatic test_basic();
        int lat;
        load_frame('{4'd9, 4'd3, 4'd7, 4'd1, 4'd5}, 1'b0);
        vecs++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL sort_flags: got busy=%b rdy=%b vld=%b want 1 0 0", busy, bus.in_ready, bus.out_valid);
        end
        wait_valid(lat);
        vecs++;
        if (lat != 17) begin
            errs++;
            $display("FAIL latency: got %0d want 17", lat);
        end
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL drain_busy: got %b want 1", busy);
        end
        drain('{4'd1, 4'd3, 4'd5, 4'd7, 4'd9}, 1'b0, "basic");
    endtask

    task automatic test_stall();
        int lat;
        load_frame('{4'd4, 4'd4, 4'd2, 4'd15, 4'd0}, 1'b0);
        wait_valid(lat);
        drain('{4'd0, 4'd2, 4'd4, 4'd4, 4'd15}, 1'b1, "stall");
    endtask

    task automatic test_back_to_back();
        int lat;
        load_frame('{4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0);
        wait_valid(lat);
        drain('{4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, "zeros");
        load_frame('{4'd15, 4'd14, 4'd13, 4'd12, 4'd11}, 1'b0);
        wait_valid(lat);
        drain('{4'd11, 4'd12, 4'd13, 4'd14, 4'd15}, 1'b0, "descend");
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        pulse_reset("rst_mid_load");
        load_frame('{4'd9, 4'd3, 4'd7, 4'd1, 4'd5}, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        pulse_reset("rst_mid_sort");
        load_frame('{4'd2, 4'd1, 4'd2, 4'd1, 4'd2}, 1'b0);
        wait_valid(lat);
        drain('{4'd1, 4'd1, 4'd2, 4'd2, 4'd2}, 1'b0, "after_rst");
        load_frame('{4'd9, 4'd3, 4'd7, 4'd1, 4'd5}, 1'b0);
        wait_valid(lat);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        pulse_reset("rst_mid_drain");
        load_frame('{4'd8, 4'd15, 4'd8, 4'd0, 4'd3}, 1'b0);
        wait_valid(lat);
        drain('{4'd0, 4'd3, 4'd8, 4'd8, 4'd15}, 1'b0, "after_drain_rst");
    endtask

    task automatic test_stray();
        int lat;
        bus.out_ready = 1'b1;
        load_frame('{4'd3, 4'd2, 4'd1, 4'd0, 4'd8}, 1'b1);
        wait_valid(lat);
        vecs++;
        if (lat != 17) begin
            errs++;
            $display("FAIL stray_latency: got %0d want 17", lat);
        end
        drain('{4'd0, 4'd1, 4'd2, 4'd3, 4'd8}, 1'b0, "stray");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_stray();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
